sa_host_ctrl: RTL and testbench
===============================

// Module: sa_host_ctrl
// PURPOSE
//  Initiator side of the successive-approximation (SA) search handshake. Takes target values from an
//  upstream valid/ready stream, buffers them, launches one SA search per target (start pulse + held
//  target), waits for done, and returns x, y and signed error (y - target) on a result valid/ready
//  stream. Sits between the host/command logic and the SA datapath block.
// PARAMETERS
//  TW       10    target / y width
//  XW       8     x width
//  DEPTH    4     target FIFO entries (power of 2, >=2)
//  TIMEOUT  1023  max cycles in WAIT before declaring a search failed
//  GAP      2     min idle cycles between sa_done (or timeout) and the next sa_start
// PORTS
//  clk        in   1      clock, all logic on rising edge
//  reset      in   1      synchronous, active-high reset
//  tgt_valid  in   1      upstream target valid
//  tgt_data   in   TW     upstream target value
//  tgt_ready  out  1      FIFO not full
//  sa_start   out  1      one-cycle start pulse to SA
//  sa_target  out  TW     target to SA, held stable from sa_start until done/timeout
//  sa_done    in   1      one-cycle completion pulse from SA; sa_x/sa_y valid that cycle
//  sa_x       in   XW     SA result x
//  sa_y       in   TW     SA result y
//  res_valid  out  1      result available
//  res_ready  in   1      downstream accepts result
//  res_x      out  XW     captured x (0 on timeout)
//  res_y      out  TW     captured y (0 on timeout)
//  res_diff   out  TW+1   signed y - target, two's complement (0 on timeout)
//  res_tmo    out  1      1 = search timed out
//  busy       out  1      high in any state other than IDLE
// BEHAVIOUR
//  Reset: FIFO emptied; state IDLE; sa_start=0, sa_target=0, res_valid=0, res_x/res_y/res_diff=0,
//   res_tmo=0, busy=0, tgt_ready=1, gap counter preloaded to 0 (first launch not delayed).
//  FIFO: push when tgt_valid&tgt_ready; pop on IDLE->LAUNCH. Push+pop same cycle when full is legal
//   only if tgt_ready was 1 that cycle (tgt_ready is registered from count, no combinational bypass).
//  FSM: IDLE   -> LAUNCH when FIFO non-empty and gap counter==0; load sa_target from FIFO head.
//       LAUNCH -> WAIT, sa_start=1 for exactly this cycle; timeout counter cleared.
//       WAIT   -> DONE on sa_done: capture sa_x, sa_y, diff = {0,sa_y} - {0,sa_target}; res_tmo=0.
//              -> DONE when counter reaches TIMEOUT with no sa_done: res_* = 0, res_tmo=1.
//              sa_done and final timeout count same cycle: done wins (res_tmo=0).
//       DONE   -> res_valid=1, outputs held stable; on res_ready -> IDLE, load gap counter=GAP.
//  Latency: FIFO push to sa_start minimum 2 cycles (empty FIFO, gap expired); sa_done to res_valid 1 cycle.
//  sa_done outside WAIT (including in LAUNCH) is ignored; no capture, no state change.
//  sa_target changes only on IDLE->LAUNCH; constant through LAUNCH/WAIT/DONE.
//  Gap counter decrements in IDLE only, saturates at 0.
//  Reset asserted in any state (mid-search included) aborts: no result emitted; SA is expected to be
//   reset by the same signal.
//  diff range: -(2^TW-1)..+(2^TW-1), fits TW+1 bits signed, no saturation needed.
// STRUCTURE
//  sa_pkg: width/depth/TIMEOUT/GAP defaults, FSM state enum {IDLE,LAUNCH,WAIT,DONE}, result struct
//   (x, y, diff, tmo).
//  Sub-module sa_tgt_fifo: DEPTH x TW synchronous FIFO, registered full/empty, ptr wrap with extra MSB.
//  Top: FSM, timeout and gap counters, result register, diff subtractor.
// TESTING (bench uses a behavioural SA model with programmable latency and y)
//  1 push 550; model returns x=137,y=549 after 12 cycles -> one sa_start pulse, sa_target=550 held,
//    res_x=137, res_y=549, res_diff=-1, res_tmo=0.
//  2 push 550,800 back-to-back, res_ready tied 1 -> second sa_start no earlier than GAP+1 cycles after
//    first res_valid; sa_target=800; second result res_diff correct for returned y.
//  3 model never asserts done, TIMEOUT=16 -> res_valid 17 cycles after sa_start, res_tmo=1, res_*=0;
//    a late sa_done afterwards is ignored.
//  4 push 5 targets with res_ready=0 -> tgt_ready drops after DEPTH entries plus one in flight; release
//    res_ready -> all 5 results in push order, none lost or duplicated.
//  5 reset pulsed while in WAIT -> all outputs at reset values next cycle; FIFO empty; no res_valid.
//  6 sa_done in same cycle as final timeout count -> res_tmo=0, captured x/y reported.

Source files
------------

// File: rtl/sa_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sa_pkg
// Purpose  : Shared defaults, FSM state encoding and counter sizing helper
//            for the SA host controller and its target FIFO.
// Revision : 1.0  initial release
// ============================================================================
package sa_pkg;

    localparam int TW_DEF      = 10;
    localparam int XW_DEF      = 8;
    localparam int DEPTH_DEF   = 4;
    localparam int TIMEOUT_DEF = 1023;
    localparam int GAP_DEF     = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_DONE   = 2'd3
    } sa_state_t;

    // Width of a counter that must hold 0..max_val; never narrower than 1 bit.
    function automatic int cnt_width(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage : sa_pkg
`default_nettype wire

// File: rtl/sa_tgt_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sa_tgt_fifo
// Purpose  : DEPTH x TW synchronous target FIFO. Pointers carry an extra
//            wrap bit; full/empty are registered so the upstream ready has
//            no combinational path from the pop side.
// Revision : 1.0  initial release
// ============================================================================
module sa_tgt_fifo #(
    parameter int TW    = 10,
    parameter int DEPTH = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic [TW-1:0] push_data,
    input  logic          pop,
    output logic [TW-1:0] head,
    output logic          full,
    output logic          empty
);
    localparam int AW = $clog2(DEPTH);

    logic [TW-1:0] r_mem [DEPTH];
    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic          r_full;
    logic          r_empty;
    logic [AW:0]   w_wptr_nxt;
    logic [AW:0]   w_rptr_nxt;
    logic          w_push;
    logic          w_pop;

    // Writes are refused when full and reads when empty, so the pointers
    // can never overrun each other regardless of the caller.
    assign w_push     = push & ~r_full;
    assign w_pop      = pop  & ~r_empty;
    assign w_wptr_nxt = r_wptr + (AW+1)'(w_push);
    assign w_rptr_nxt = r_rptr + (AW+1)'(w_pop);

    // Pointer and flag registers; flags are computed from next-state pointers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_full  <= 1'b0;
            r_empty <= 1'b1;
        end else begin
            r_wptr  <= w_wptr_nxt;
            r_rptr  <= w_rptr_nxt;
            r_full  <= ((w_wptr_nxt - w_rptr_nxt) == (AW+1)'(DEPTH));
            r_empty <= (w_wptr_nxt == w_rptr_nxt);
        end
    end

    // Storage array; contents need no reset since empty gates every read.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr[AW-1:0]] <= push_data;
        end
    end

    assign head  = r_mem[r_rptr[AW-1:0]];
    assign full  = r_full;
    assign empty = r_empty;

endmodule : sa_tgt_fifo
`default_nettype wire

// File: rtl/sa_host_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : sa_host_ctrl
// Purpose  : Initiator side of the SA search handshake. Buffers targets,
//            launches one search per target, waits for done or timeout and
//            returns x, y and signed (y - target) on a result stream.
// Revision : 1.0  initial release
// ============================================================================
module sa_host_ctrl
    import sa_pkg::*;
#(
    parameter int TW      = TW_DEF,
    parameter int XW      = XW_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF,
    parameter int GAP     = GAP_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          tgt_valid,
    input  logic [TW-1:0] tgt_data,
    output logic          tgt_ready,
    output logic          sa_start,
    output logic [TW-1:0] sa_target,
    input  logic          sa_done,
    input  logic [XW-1:0] sa_x,
    input  logic [TW-1:0] sa_y,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [XW-1:0] res_x,
    output logic [TW-1:0] res_y,
    output logic [TW:0]   res_diff,
    output logic          res_tmo,
    output logic          busy
);
    localparam int CW = cnt_width(TIMEOUT);
    localparam int GW = cnt_width(GAP);

    typedef struct packed {
        logic [XW-1:0] x;
        logic [TW-1:0] y;
        logic [TW:0]   diff;
        logic          tmo;
    } result_t;

    sa_state_t     r_state;
    sa_state_t     w_state_nxt;
    logic [TW-1:0] r_target;
    logic [CW-1:0] r_tcnt;
    logic [GW-1:0] r_gap;
    result_t       r_res;

    logic          w_fifo_full;
    logic          w_fifo_empty;
    logic [TW-1:0] w_head;
    logic          w_pop;
    logic          w_tmo_hit;
    logic          w_cap_done;
    logic          w_cap_tmo;
    logic          w_res_accept;
    logic [TW:0]   w_diff;

    sa_tgt_fifo #(
        .TW    (TW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (tgt_valid),
        .push_data (tgt_data),
        .pop       (w_pop),
        .head      (w_head),
        .full      (w_fifo_full),
        .empty     (w_fifo_empty)
    );

    // Last WAIT cycle: r_tcnt counts completed WAIT cycles from zero.
    assign w_tmo_hit = (r_tcnt == CW'(TIMEOUT - 1));

    // Zero-extend both operands so the TW+1 bit result is signed y - target.
    assign w_diff = {1'b0, sa_y} - {1'b0, r_target};

    // Next-state and handshake decode; sa_done wins over a same-cycle timeout.
    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = 1'b0;
        w_cap_done   = 1'b0;
        w_cap_tmo    = 1'b0;
        w_res_accept = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_fifo_empty && (r_gap == '0)) begin
                    w_state_nxt = ST_LAUNCH;
                    w_pop       = 1'b1;
                end
            end
            ST_LAUNCH: begin
                w_state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (sa_done) begin
                    w_state_nxt = ST_DONE;
                    w_cap_done  = 1'b1;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_DONE;
                    w_cap_tmo   = 1'b1;
                end
            end
            ST_DONE: begin
                if (res_ready) begin
                    w_state_nxt  = ST_IDLE;
                    w_res_accept = 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Target is latched only when a FIFO entry is popped for a new search.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_target <= '0;
        end else if (w_pop) begin
            r_target <= w_head;
        end
    end

    // Timeout counter: cleared in LAUNCH, advances through WAIT.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_tcnt <= '0;
        end else if (r_state == ST_LAUNCH) begin
            r_tcnt <= '0;
        end else if ((r_state == ST_WAIT) && !w_tmo_hit) begin
            r_tcnt <= r_tcnt + CW'(1);
        end
    end

    // Gap counter: loaded when a result is taken, drains only while IDLE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_gap <= '0;
        end else if (w_res_accept) begin
            r_gap <= GW'(GAP);
        end else if ((r_state == ST_IDLE) && (r_gap != '0)) begin
            r_gap <= r_gap - GW'(1);
        end
    end

    // Result register, written once per search and held through DONE.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_res <= '0;
        end else if (w_cap_done) begin
            r_res.x    <= sa_x;
            r_res.y    <= sa_y;
            r_res.diff <= w_diff;
            r_res.tmo  <= 1'b0;
        end else if (w_cap_tmo) begin
            r_res.x    <= '0;
            r_res.y    <= '0;
            r_res.diff <= '0;
            r_res.tmo  <= 1'b1;
        end
    end

    assign tgt_ready = ~w_fifo_full;
    assign sa_start  = (r_state == ST_LAUNCH);
    assign sa_target = r_target;
    assign res_valid = (r_state == ST_DONE);
    assign res_x     = r_res.x;
    assign res_y     = r_res.y;
    assign res_diff  = r_res.diff;
    assign res_tmo   = r_res.tmo;
    assign busy      = (r_state != ST_IDLE);

endmodule : sa_host_ctrl
`default_nettype wire

// File: tb/tb_sa_host_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sa_host_ctrl
// Purpose  : Self-checking bench for sa_host_ctrl with a behavioural SA
//            responder (programmable latency and result) and a cycle-level
//            reference model of the launch/result protocol.
// Revision : 1.0  initial release
// ============================================================================
module tb_sa_host_ctrl;
    localparam int TW      = 10;
    localparam int XW      = 8;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int GAP     = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          tgt_valid;
    logic [TW-1:0] tgt_data;
    logic          tgt_ready;
    logic          sa_start;
    logic [TW-1:0] sa_target;
    logic          sa_done;
    logic [XW-1:0] sa_x;
    logic [TW-1:0] sa_y;
    logic          res_valid;
    logic          res_ready;
    logic [XW-1:0] res_x;
    logic [TW-1:0] res_y;
    logic [TW:0]   res_diff;
    logic          res_tmo;
    logic          busy;

    always #5 clk = ~clk;

    sa_host_ctrl #(
        .TW(TW), .XW(XW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .GAP(GAP)
    ) dut (
        .clk(clk), .reset(reset),
        .tgt_valid(tgt_valid), .tgt_data(tgt_data), .tgt_ready(tgt_ready),
        .sa_start(sa_start), .sa_target(sa_target),
        .sa_done(sa_done), .sa_x(sa_x), .sa_y(sa_y),
        .res_valid(res_valid), .res_ready(res_ready),
        .res_x(res_x), .res_y(res_y), .res_diff(res_diff), .res_tmo(res_tmo),
        .busy(busy)
    );

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    typedef struct {
        logic [TW-1:0] t;
        int            pcyc;
    } ent_t;

    logic [TW-1:0] pq[$];     // targets still to be offered upstream
    ent_t          tq[$];     // targets held by the DUT, not yet launched

    // Reference view of the search in flight
    bit            s_active = 0;
    logic [TW-1:0] s_tgt;
    int            s_start;
    int            s_lat;
    bit            s_stray;
    logic [XW-1:0] s_x;
    logic [TW-1:0] s_y;
    int            exp_cyc;
    logic [XW-1:0] e_x;
    logic [TW-1:0] e_y;
    logic [TW:0]   e_diff;
    logic          e_tmo;
    int            earliest = 0;

    // Scenario knobs
    int            lat_lo = 1, lat_hi = 1;
    bit            fixed_resp = 0;
    logic [XW-1:0] fx;
    logic [TW-1:0] fy;
    int            rr_mode = 1;
    int            valid_pct = 100;
    bit            stray_en = 0;
    int            n_push = 0, n_res = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: advance, update the model from handshakes, compare, drive.
    task automatic step();
        bit acc_push, acc_res, was_rst, want_start;
        int exp_start, d;
        acc_push = tgt_valid && tgt_ready;
        acc_res  = res_valid && res_ready;
        was_rst  = reset;
        @(posedge clk); #1; cyc++;

        if (was_rst) begin
            tq.delete();
            s_active = 0;
            earliest = 0;
            chk("rst_sa_target", 32'(sa_target), 0);
            chk("rst_res_x",     32'(res_x), 0);
            chk("rst_res_y",     32'(res_y), 0);
            chk("rst_res_diff",  32'(res_diff), 0);
            chk("rst_res_tmo",   32'(res_tmo), 0);
        end else begin
            if (acc_push) begin
                tq.push_back('{t: tgt_data, pcyc: cyc - 1});
                void'(pq.pop_front());
                n_push++;
            end
            if (acc_res) begin
                s_active = 0;
                n_res++;
                earliest = (cyc - 1) + GAP + 2;
            end
        end

        exp_start = -1;
        if (tq.size() > 0) begin
            exp_start = (tq[0].pcyc + 2 > earliest) ? tq[0].pcyc + 2 : earliest;
        end
        want_start = !s_active && (tq.size() > 0) && (cyc >= exp_start);
        chk("sa_start", 32'(sa_start), 32'(want_start));

        if (want_start) begin
            s_active = 1;
            s_tgt    = tq.pop_front().t;
            s_start  = cyc;
            s_lat    = (lat_hi == 0) ? 0 : int'($urandom_range(lat_hi, lat_lo));
            s_stray  = stray_en && ($urandom_range(1) == 1);
            s_x      = fixed_resp ? fx : XW'($urandom);
            s_y      = fixed_resp ? fy : TW'($urandom);
            if (s_lat >= 1 && s_lat <= TIMEOUT) begin
                exp_cyc = cyc + s_lat + 1;
                e_x     = s_x;
                e_y     = s_y;
                d       = int'(s_y) - int'(s_tgt);
                e_diff  = d[TW:0];
                e_tmo   = 1'b0;
            end else begin
                exp_cyc = cyc + TIMEOUT + 1;
                e_x     = '0;
                e_y     = '0;
                e_diff  = '0;
                e_tmo   = 1'b1;
            end
        end

        chk("busy",      32'(busy), 32'(s_active));
        chk("tgt_ready", 32'(tgt_ready), 32'(tq.size() < DEPTH));
        chk("res_valid", 32'(res_valid), 32'(s_active && cyc >= exp_cyc));
        if (s_active) begin
            chk("sa_target_hold", 32'(sa_target), 32'(s_tgt));
            if (cyc >= exp_cyc) begin
                chk("res_x",    32'(res_x),    32'(e_x));
                chk("res_y",    32'(res_y),    32'(e_y));
                chk("res_diff", 32'(res_diff), 32'(e_diff));
                chk("res_tmo",  32'(res_tmo),  32'(e_tmo));
            end
        end

        // Drive inputs for the coming cycle
        if (!reset && pq.size() > 0 && $urandom_range(99) < valid_pct) begin
            tgt_valid = 1'b1;
            tgt_data  = pq[0];
        end else begin
            tgt_valid = 1'b0;
            tgt_data  = TW'($urandom);
        end
        res_ready = (rr_mode == 2) ? 1'($urandom_range(1)) : 1'(rr_mode);
        sa_done   = 1'b0;
        sa_x      = XW'($urandom);
        sa_y      = TW'($urandom);
        if (s_active) begin
            if (s_lat >= 1 && cyc == s_start + s_lat) begin
                sa_done = 1'b1;
                sa_x    = s_x;
                sa_y    = s_y;
            end else if (s_stray && cyc == s_start) begin
                sa_done = 1'b1;
            end else if (e_tmo && cyc == exp_cyc) begin
                sa_done = 1'b1;
            end
        end
    endtask

    task automatic run(input int max_cyc);
        int n;
        n = 0;
        while ((pq.size() > 0 || tq.size() > 0 || s_active) && n < max_cyc) begin
            step();
            n++;
        end
        chk("drain", 32'(pq.size() + tq.size() + int'(s_active)), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base_push, base_res, n;
        reset = 1'b1; tgt_valid = 1'b0; tgt_data = '0;
        sa_done = 1'b0; sa_x = '0; sa_y = '0; res_ready = 1'b0;
        step(); step();
        reset = 1'b0;
        step();

        // 1: single target, fixed SA response after 12 cycles
        fixed_resp = 1; fx = 8'd137; fy = 10'd549; lat_lo = 12; lat_hi = 12;
        rr_mode = 1;
        pq.push_back(10'd550);
        run(200);

        // 2: two back-to-back targets, random y, ready tied high
        fixed_resp = 0; lat_lo = 3; lat_hi = 10;
        pq.push_back(10'd550); pq.push_back(10'd800);
        run(300);

        // 3: timeout, late done in DONE, and a stray done in LAUNCH
        lat_lo = 0; lat_hi = 0; rr_mode = 2; stray_en = 1;
        pq.push_back(TW'($urandom));
        run(300);
        lat_lo = TIMEOUT + 1; lat_hi = TIMEOUT + 1;
        pq.push_back(TW'($urandom));
        run(300);
        stray_en = 0;

        // 4: five targets with results blocked, then released
        lat_lo = 2; lat_hi = 5; rr_mode = 0;
        base_push = n_push; base_res = n_res;
        for (int i = 0; i < 5; i++) pq.push_back(TW'($urandom));
        for (int i = 0; i < 30; i++) step();
        chk("full_pushes", 32'(n_push - base_push), 5);
        chk("full_ready", 32'(tgt_ready), 0);
        rr_mode = 1;
        run(500);
        chk("results_5", 32'(n_res - base_res), 5);

        // 5: reset while a search is in WAIT
        lat_lo = 0; lat_hi = 0;
        pq.push_back(TW'($urandom)); pq.push_back(TW'($urandom));
        n = 0;
        while (!(s_active && cyc >= s_start + 3) && n < 100) begin
            step(); n++;
        end
        chk("reached_wait", 32'(s_active), 1);
        reset = 1'b1; pq.delete(); tgt_valid = 1'b0;
        step();
        reset = 1'b0;
        for (int i = 0; i < 10; i++) step();

        // 6: done coincides with the last timeout cycle
        lat_lo = TIMEOUT; lat_hi = TIMEOUT; rr_mode = 2;
        pq.push_back(TW'($urandom)); pq.push_back(TW'($urandom));
        run(300);

        // Random mix of latencies straddling the timeout boundary
        lat_lo = 1; lat_hi = TIMEOUT + 4; rr_mode = 2; valid_pct = 70; stray_en = 1;
        base_push = n_push; base_res = n_res;
        for (int i = 0; i < 40; i++) pq.push_back(TW'($urandom));
        run(5000);
        chk("results_rand", 32'(n_res - base_res), 40);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule : tb_sa_host_ctrl
`default_nettype wire
